// File: rtl/down_timer_reload.sv
// rtl/down_timer_reload.sv - loadable down-counting timer with clamp, abort and auto-reload
package down_timer_reload_pkg;
    function automatic integer CeilLog2(input integer x);
        integer r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < x) r = i + 1;
        end
        return r;
    endfunction
endpackage

module down_timer_reload
    import down_timer_reload_pkg::*;
#(
    parameter integer MAXIMUM_VALUE     = 10,
    parameter integer NBITS_FOR_COUNTER = CeilLog2(MAXIMUM_VALUE + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NBITS_FOR_COUNTER-1:0] load_value,
    input  logic                         enable,
    input  logic                         auto_reload,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         flag,
    output logic [NBITS_FOR_COUNTER-1:0] CountOut
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [NBITS_FOR_COUNTER-1:0] MAX_V = NBITS_FOR_COUNTER'(MAXIMUM_VALUE);
    localparam logic [NBITS_FOR_COUNTER-1:0] ONE_V = NBITS_FOR_COUNTER'(1);

    state_t                         state_q, state_d;
    logic [NBITS_FOR_COUNTER-1:0]   count_q, count_d;
    logic [NBITS_FOR_COUNTER-1:0]   reload_q, reload_d;
    logic                           done_q, done_d;
    logic [NBITS_FOR_COUNTER-1:0]   eff;

    assign eff = (load_value > MAX_V) ? MAX_V : load_value;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    reload_d = eff;
                    if (eff != '0) begin
                        count_d = eff;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (start) begin
                    count_d  = eff;
                    reload_d = eff;
                    // A zero restart would otherwise park RUN at 0; treat it as an instant expiry.
                    if (eff == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (enable) begin
                    if (count_q > ONE_V) begin
                        count_d = count_q - ONE_V;
                    end else if (count_q == ONE_V) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign flag     = (count_q == '0);
    assign CountOut = count_q;

endmodule
